// File: rtl/dram_lane_server_pkg.sv
// Shared constants, the memory request record and a lane one-hot helper
// for the DRAM lane server and its round-robin arbiter.
package dram_lane_server_pkg;

    localparam int LANES   = 16;
    localparam int GROUP   = 8;
    localparam int DEPTH   = 4;
    localparam int LANE_W  = $clog2(LANES);
    localparam int GROUP_W = $clog2(GROUP);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  wdata;
    } mem_req_t;

    function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
        lane_onehot = {{(LANES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/dram_lane_server_lane_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible lane at or after the pointer,
// and the pointer moves just past the winner whenever a grant is taken.
module dram_lane_server_lane_rr_arbiter
    import dram_lane_server_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LANES-1:0]  eligible,
    input  logic              advance,
    output logic [LANES-1:0]  grant,
    output logic [LANE_W-1:0] index,
    output logic              any
);

    logic [LANE_W-1:0] ptr_r;
    logic [LANE_W-1:0] cand_s;

    // Walk from farthest to nearest so the lane closest to the pointer wins.
    always_comb begin
        index  = ptr_r;
        any    = 1'b0;
        cand_s = ptr_r;
        for (int k = LANES - 1; k >= 0; k--) begin
            cand_s = ptr_r + LANE_W'(k);
            index  = eligible[cand_s] ? cand_s : index;
            any    = any | eligible[cand_s];
        end
        grant = any ? lane_onehot(index) : {LANES{1'b0}};
    end

    // Rotating priority pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {LANE_W{1'b0}};
        end else if (advance) begin
            ptr_r <= index + LANE_W'(1);
        end
    end

endmodule

// File: rtl/dram_lane_server.sv
// Serves 16 per-lane byte DRAM requests over one pipelined memory port,
// tracking issued requests in an in-order tag FIFO to route responses back.
module dram_lane_server
    import dram_lane_server_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       dram_en,
    input  logic [LANES/GROUP-1:0] dram_rdwr,
    input  logic [LANES-1:0][63:0] dram_addr,
    input  logic [LANES-1:0][7:0]  data_to_dram,
    output logic [LANES-1:0]       dram_valid,
    output logic [LANES-1:0][7:0]  data_from_dram,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [63:0]            mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rsp_valid,
    input  logic [7:0]             mem_rdata,
    output logic                   err
);

    logic                          rq_valid_r;
    logic [LANE_W-1:0]             rq_lane_r;
    mem_req_t                      rq_r;
    logic [LANES-1:0]              pending_r;
    logic [LANES-1:0]              pend_we_r;
    logic [DEPTH-1:0][LANE_W-1:0]  fifo_r;
    logic [PTR_W-1:0]              head_r;
    logic [PTR_W-1:0]              tail_r;
    logic [CNT_W-1:0]              count_r;

    logic [LANES-1:0]  eligible_s;
    logic [LANES-1:0]  grant_s;
    logic [LANES-1:0]  load_mask_s;
    logic [LANES-1:0]  rsp_hot_s;
    logic [LANE_W-1:0] win_s;
    logic [LANE_W-1:0] head_lane_s;
    logic              any_s;
    logic              room_s;
    logic              load_s;
    logic              push_s;
    logic              pop_s;
    logic              we_s;

    // dram_valid doubles as the one-cycle cooldown after a completion.
    assign eligible_s  = dram_en & ~pending_r & ~dram_valid;
    assign room_s      = (count_r + CNT_W'(rq_valid_r)) < CNT_W'(DEPTH);
    assign load_s      = (~rq_valid_r | mem_gnt) & room_s & any_s;
    assign push_s      = rq_valid_r & mem_gnt;
    assign head_lane_s = fifo_r[head_r];
    assign pop_s       = mem_rsp_valid & (count_r != {CNT_W{1'b0}});
    assign rsp_hot_s   = pop_s ? lane_onehot(head_lane_s) : {LANES{1'b0}};
    assign load_mask_s = load_s ? grant_s : {LANES{1'b0}};
    assign we_s        = dram_rdwr[win_s[LANE_W-1:GROUP_W]];

    assign mem_req   = rq_valid_r;
    assign mem_we    = rq_r.we;
    assign mem_addr  = rq_r.addr;
    assign mem_wdata = rq_r.wdata;

    dram_lane_server_lane_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible_s),
        .advance  (load_s),
        .grant    (grant_s),
        .index    (win_s),
        .any      (any_s)
    );

    // Request register; a held request is only replaced once granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_valid_r <= 1'b0;
            rq_lane_r  <= {LANE_W{1'b0}};
            rq_r       <= '0;
        end else if (load_s) begin
            rq_valid_r <= 1'b1;
            rq_lane_r  <= win_s;
            rq_r.we    <= we_s;
            rq_r.addr  <= dram_addr[win_s];
            rq_r.wdata <= data_to_dram[win_s];
        end else if (push_s) begin
            rq_valid_r <= 1'b0;
        end
    end

    // In-order tag FIFO of lanes with a request accepted by memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_r  <= '0;
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[tail_r] <= rq_lane_r;
                tail_r         <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-lane outstanding flag and captured direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= {LANES{1'b0}};
            pend_we_r <= {LANES{1'b0}};
        end else begin
            pending_r <= (pending_r | load_mask_s) & ~rsp_hot_s;
            pend_we_r <= (pend_we_r & ~load_mask_s) | (load_mask_s & {LANES{we_s}});
        end
    end

    // Completion pulse, read data return and sticky underflow error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dram_valid     <= {LANES{1'b0}};
            data_from_dram <= '0;
            err            <= 1'b0;
        end else begin
            dram_valid <= rsp_hot_s;
            if (pop_s && !pend_we_r[head_lane_s]) begin
                data_from_dram[head_lane_s] <= mem_rdata;
            end
            if (mem_rsp_valid && (count_r == {CNT_W{1'b0}})) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_lane_server.sv
// Self-checking bench for dram_lane_server: directed scenarios plus random
// traffic, all compared each cycle against a queue-based behavioural model.
module tb_dram_lane_server;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       dram_en;
    logic [1:0]        dram_rdwr;
    logic [15:0][63:0] dram_addr;
    logic [15:0][7:0]  data_to_dram;
    logic [15:0]       dram_valid;
    logic [15:0][7:0]  data_from_dram;
    logic              mem_req;
    logic              mem_we;
    logic [63:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_gnt;
    logic              mem_rsp_valid;
    logic [7:0]        mem_rdata;
    logic              err;

    int total = 0;
    int bad   = 0;

    dram_lane_server dut (
        .clk            (clk),
        .reset          (reset),
        .dram_en        (dram_en),
        .dram_rdwr      (dram_rdwr),
        .dram_addr      (dram_addr),
        .data_to_dram   (data_to_dram),
        .dram_valid     (dram_valid),
        .data_from_dram (data_from_dram),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rdata      (mem_rdata),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic              m_rq_valid;
    int                m_rq_lane;
    logic              m_rq_we;
    logic [63:0]       m_rq_addr;
    logic [7:0]        m_rq_wdata;
    logic [15:0]       m_pending;
    logic [15:0]       m_lane_we;
    logic [15:0]       m_dv;
    logic [15:0][7:0]  m_dfd;
    logic              m_err;
    int                m_ptr;
    int                m_tags[$];

    always @(posedge clk or posedge reset) begin : model
        int  cnt;
        int  w;
        int  l;
        int  lane;
        bit  xfer;
        bit  pop;
        if (reset) begin
            m_rq_valid = 1'b0; m_rq_lane = 0; m_rq_we = 1'b0;
            m_rq_addr = 64'h0; m_rq_wdata = 8'h00;
            m_pending = 16'h0; m_lane_we = 16'h0; m_dv = 16'h0;
            m_dfd = '0; m_err = 1'b0; m_ptr = 0;
            m_tags.delete();
        end else begin
            cnt  = m_tags.size();
            xfer = m_rq_valid && mem_gnt;
            pop  = mem_rsp_valid && (cnt > 0);
            if (mem_rsp_valid && cnt == 0) m_err = 1'b1;
            l = pop ? m_tags[0] : -1;
            w = -1;
            if ((!m_rq_valid || mem_gnt) && (cnt + int'(m_rq_valid)) < 4) begin
                for (int k = 0; k < 16; k++) begin
                    lane = (m_ptr + k) % 16;
                    if (w < 0 && dram_en[lane] && !m_pending[lane] && !m_dv[lane]) w = lane;
                end
            end
            if (xfer) m_tags.push_back(m_rq_lane);
            if (pop) void'(m_tags.pop_front());
            m_dv = 16'h0;
            if (pop) begin
                m_dv[l] = 1'b1;
                m_pending[l] = 1'b0;
                if (!m_lane_we[l]) m_dfd[l] = mem_rdata;
            end
            if (w >= 0) begin
                m_pending[w] = 1'b1;
                m_lane_we[w] = dram_rdwr[w / 8];
                m_rq_valid = 1'b1;
                m_rq_lane  = w;
                m_rq_we    = dram_rdwr[w / 8];
                m_rq_addr  = dram_addr[w];
                m_rq_wdata = data_to_dram[w];
                m_ptr      = (w + 1) % 16;
            end else if (xfer) begin
                m_rq_valid = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("mem_req", 64'(mem_req), 64'(m_rq_valid));
        if (m_rq_valid) begin
            check("mem_addr", mem_addr, m_rq_addr);
            check("mem_we", 64'(mem_we), 64'(m_rq_we));
            check("mem_wdata", 64'(mem_wdata), 64'(m_rq_wdata));
        end
        check("dram_valid", 64'(dram_valid), 64'(m_dv));
        for (int i = 0; i < 16; i++) begin
            check("data_from_dram", 64'(data_from_dram[i]), 64'(m_dfd[i]));
        end
        check("err", 64'(err), 64'(m_err));
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    int order[$];
    int nxfer;

    initial begin
        reset = 1'b1; dram_en = 16'h0; dram_rdwr = 2'b00; dram_addr = '0;
        data_to_dram = '0; mem_gnt = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 8'h00;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_dram_valid", 64'(dram_valid), 64'h0);
        check("rst_dfd", 64'(|data_from_dram), 64'h0);
        check("rst_err", 64'(err), 64'h0);

        // Single read, lane 3
        dram_en[3] = 1'b1; dram_addr[3] = 64'h1000; mem_gnt = 1'b1;
        step();
        check("rd3_req", 64'(mem_req), 64'h1);
        check("rd3_addr", mem_addr, 64'h1000);
        check("rd3_we", 64'(mem_we), 64'h0);
        dram_en[3] = 1'b0;
        step();
        mem_gnt = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 8'hA5;
        step();
        mem_rsp_valid = 1'b0;
        check("rd3_valid", 64'(dram_valid), 64'h0008);
        check("rd3_data", 64'(data_from_dram[3]), 64'hA5);
        check("model_rd3_valid", 64'(m_dv), 64'h0008);
        step();
        check("rd3_pulse_end", 64'(dram_valid), 64'h0);

        // Write, lane 9
        dram_en[9] = 1'b1; dram_rdwr = 2'b10; data_to_dram[9] = 8'h3C;
        dram_addr[9] = 64'h20; mem_gnt = 1'b1;
        step();
        check("wr9_we", 64'(mem_we), 64'h1);
        check("wr9_wdata", 64'(mem_wdata), 64'h3C);
        check("wr9_addr", mem_addr, 64'h20);
        dram_en[9] = 1'b0;
        step();
        mem_gnt = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 8'hEE;
        step();
        mem_rsp_valid = 1'b0; dram_rdwr = 2'b00;
        check("wr9_valid", 64'(dram_valid), 64'h0200);
        check("wr9_data_held", 64'(data_from_dram[9]), 64'h00);
        step();

        // Grant stall, lane 5
        dram_en[5] = 1'b1; dram_addr[5] = 64'h55; data_to_dram[5] = 8'h11; mem_gnt = 1'b0;
        step();
        dram_en[5] = 1'b0; dram_addr[5] = 64'h99; data_to_dram[5] = 8'h22;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 64'(mem_req), 64'h1);
            check("stall_addr", mem_addr, 64'h55);
            check("stall_wdata", 64'(mem_wdata), 64'h11);
            step();
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 8'h77;
        step();
        mem_rsp_valid = 1'b0;
        check("stall_valid", 64'(dram_valid), 64'h0020);
        check("stall_data", 64'(data_from_dram[5]), 64'h77);
        step();

        // Stray response sets sticky err
        mem_rsp_valid = 1'b1; mem_rdata = 8'h44;
        step();
        mem_rsp_valid = 1'b0;
        check("err_set", 64'(err), 64'h1);
        check("err_no_valid", 64'(dram_valid), 64'h0);
        repeat (2) step();
        check("err_sticky", 64'(err), 64'h1);
        reset = 1'b1;
        #1;
        check("err_cleared", 64'(err), 64'h0);
        step();
        reset = 1'b0;
        step();

        // Reset with three outstanding, then a clean lane 0 read
        for (int i = 0; i < 3; i++) dram_addr[i] = 64'(i * 256);
        dram_en = 16'h0007; mem_gnt = 1'b1;
        repeat (3) step();
        dram_en = 16'h0;
        step();
        check("model_outstanding", 64'(m_tags.size()), 64'd3);
        reset = 1'b1;
        #1;
        check("midrst_req", 64'(mem_req), 64'h0);
        check("midrst_valid", 64'(dram_valid), 64'h0);
        check("midrst_dfd", 64'(|data_from_dram), 64'h0);
        check("midrst_err", 64'(err), 64'h0);
        step();
        reset = 1'b0;
        dram_en[0] = 1'b1; dram_addr[0] = 64'h40;
        step();
        dram_en[0] = 1'b0;
        step();
        mem_rsp_valid = 1'b1; mem_rdata = 8'h5B;
        step();
        mem_rsp_valid = 1'b0;
        check("postrst_valid", 64'(dram_valid), 64'h0001);
        check("postrst_data", 64'(data_from_dram[0]), 64'h5B);
        check("postrst_err", 64'(err), 64'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // All 16 lanes, grant held high: round-robin order and back-pressure
        for (int i = 0; i < 16; i++) dram_addr[i] = 64'(i * 256);
        dram_en = 16'hFFFF; mem_gnt = 1'b1; mem_rsp_valid = 1'b0;
        nxfer = 0;
        for (int c = 0; c < 8; c++) begin
            if (mem_req && mem_gnt) begin
                nxfer++;
                order.push_back(int'(mem_addr[11:8]));
            end
            step();
        end
        check("bp_xfers", 64'(nxfer), 64'd4);
        check("bp_req_idle", 64'(mem_req), 64'h0);
        for (int c = 0; c < 80; c++) begin
            mem_rsp_valid = (m_tags.size() > 0);
            mem_rdata = 8'($urandom);
            if (mem_req && mem_gnt && order.size() < 17) order.push_back(int'(mem_addr[11:8]));
            step();
        end
        check("rr_count", 64'(order.size()), 64'd17);
        for (int i = 0; i < order.size(); i++) begin
            check("rr_order", 64'(order[i]), 64'(i % 16));
        end
        dram_en = 16'h0;
        for (int c = 0; c < 20; c++) begin
            mem_rsp_valid = (m_tags.size() > 0);
            step();
        end

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            dram_en = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) dram_rdwr = 2'($urandom);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    dram_addr[i] = {$urandom, $urandom};
                    data_to_dram[i] = 8'($urandom);
                end
            end
            mem_gnt = ($urandom_range(0, 3) != 0);
            mem_rsp_valid = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata = 8'($urandom);
            step();
        end
        dram_en = 16'h0; mem_gnt = 1'b1;
        for (int c = 0; c < 30; c++) begin
            mem_rsp_valid = (m_tags.size() > 0);
            step();
        end
        check("drain_err", 64'(err), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_lane_server.md
# dram_lane_server

Downstream neighbour of the serializer top level: it services the 16 per-lane byte DRAM requests (lanes 7:0 from fetch, lanes 15:8 from ser_aggregate) on a single byte-wide pipelined memory port. It arbitrates round-robin among lanes and tracks issued requests in an in-order tag FIFO. It routes each memory response back to the requesting lane as a one-cycle `dram_valid` pulse.

## Interface
- LANES, 16, number of requester lanes
- GROUP, 8, lanes sharing one rdwr bit (lane i uses rdwr[i/GROUP])
- DEPTH, 4, max outstanding memory requests (tag FIFO depth, power of 2)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dram_en  in  LANES  per-lane request level
- dram_rdwr  in  LANES/GROUP  per-group direction, 1 = write, 0 = read
- dram_addr  in  LANES×64  per-lane byte address
- data_to_dram  in  LANES×8  per-lane write byte
- dram_valid  out  LANES  one-cycle completion pulse per lane
- data_from_dram  out  LANES×8  read byte, valid with dram_valid
- mem_req  out  1  request to memory
- mem_we  out  1  1 = write
- mem_addr  out  64  byte address
- mem_wdata  out  8  write byte
- mem_gnt  in  1  memory accepts request this cycle (mem_req & mem_gnt = transfer)
- mem_rsp_valid  in  1  in-order response for reads and writes
- mem_rdata  in  8  read byte, valid with mem_rsp_valid
- err  out  1  sticky: response received with tag FIFO empty

## Operation
- Lane i eligible = dram_en[i] & ~pending[i] & ~cooldown[i].
- Request register (rq_valid, lane, we, addr, wdata) drives mem_*; mem_req = rq_valid.
- Load: when (~rq_valid | mem_gnt) & any eligible lane, the round-robin winner is captured. Write data and addr are sampled at capture. pending[winner] is set. The RR pointer moves to winner+1 mod LANES.
- Transfer (mem_req & mem_gnt): push rq lane id into tag FIFO. rq_valid clears unless reloaded in the same cycle.
- Back-pressure: no capture while count + rq_valid ≥ DEPTH. Registered count is used, with no pop bypass.
- Response: mem_rsp_valid pops FIFO head lane L. Next cycle dram_valid[L]=1 and data_from_dram[L]=mem_rdata (write: data_from_dram[L] holds its last value). pending[L] clears and cooldown[L] is set for exactly that dram_valid cycle.
- Response with empty FIFO: ignored, err set until reset.
- Once captured, a request is never retracted. Dropping dram_en afterwards still yields dram_valid, which the requester ignores.
- Simultaneous push and pop: both occur and count is unchanged. Pointers wrap mod DEPTH.

## Timing
- Reset: all outputs 0. rq_valid, pending, cooldown, FIFO, and count are cleared. RR pointer = 0. err = 0.
- Min latency: dram_en seen in cycle 0 → mem_req in cycle 1 → (gnt in 1, rsp in 2) → dram_valid in cycle 3.
- Requester holds addr, data, and rdwr stable from asserting en until capture. In the dram_valid cycle it updates or drops en, and the lane is re-eligible the following cycle.
- Throughput: one request per cycle while mem_gnt=1 and the FIFO is not full.
- mem_addr, mem_we, and mem_wdata are stable while mem_req=1 & mem_gnt=0.
- Reset mid-operation: in-flight requests are discarded. Post-reset stray responses set err.

## Structure
- Shared package: LANE_W = $clog2(LANES) constant; MEM_REQ struct (we, addr[63:0], wdata[7:0]).
- Sub-module lane_rr_arbiter: eligible vector + advance strobe → one-hot grant, index, any. It holds the RR pointer.
- Tag FIFO kept inline: DEPTH×LANE_W registers, head, tail, count.

## Test plan
- Single read, lane 3, addr 0x1000, memory returns 0xA5 one cycle after gnt → dram_valid[3] and data_from_dram[3]=0xA5 in cycle 3, other lanes 0.
- All 16 lanes request together with gnt held 1 → grants issued in order 0,1,…,15, with lane 0 repeated only after 15. Back-pressure verified: at most 4 grants before the first response.
- Lane 9 write (rdwr[1]=1), data 0x3C, addr 0x20 → mem_we=1, mem_wdata=0x3C; dram_valid[9] one cycle after the response.
- mem_gnt held 0 for 5 cycles → mem_req stays 1 with addr and data unchanged; lane en changes are ignored.
- Response with no outstanding request → err=1 and stays high; no dram_valid. Reset clears it.
- Reset asserted with 3 outstanding → all outputs 0 immediately. After release, a new lane 0 read completes normally.
